// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - instruction fetch queue with one-cycle-latency memory reads
module inst_fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic [WIDTH-1:0]           inst_rdaddress,
    output logic                       inst_rden,
    input  logic [WIDTH-1:0]           inst_q,
    input  logic                       redirect,
    input  logic [WIDTH-1:0]           redirect_pc,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_inst,
    output logic [WIDTH-1:0]           out_pc,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [WIDTH-1:0] inst_mem [DEPTH];
    logic [WIDTH-1:0] pc_mem   [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    occ;
    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] req_pc;
    logic             inflight;
    logic             discard;
    logic [CW:0]      committed;
    logic             head_valid;
    logic             push;
    logic             pop;

    // An outstanding read already owns a slot, so it counts against free space.
    assign committed  = {1'b0, occ} + {{CW{1'b0}}, inflight};
    assign head_valid = (occ != '0);

    assign inst_rden      = !reset && !redirect && (committed < DEPTH_W);
    assign inst_rdaddress = fetch_pc;

    assign push = inflight && !discard && !redirect && !reset;
    assign pop  = head_valid && out_ready && !redirect && !reset;

    assign out_valid = !reset && head_valid;
    assign out_inst  = out_valid ? inst_mem[head] : '0;
    assign out_pc    = out_valid ? pc_mem[head]   : '0;
    assign count     = occ;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= '0;
            req_pc   <= '0;
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            inflight <= 1'b0;
            discard  <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            inflight <= 1'b0;
            discard  <= 1'b1;
        end else begin
            inflight <= inst_rden;
            discard  <= 1'b0;
            if (inst_rden) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + WIDTH'(1);
            end
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage carries no reset; only entries behind a nonzero count are ever observed.
    always_ff @(posedge clock) begin
        if (push) begin
            inst_mem[tail] <= inst_q;
            pc_mem[tail]   <= req_pc;
        end
    end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 32, instruction and address width.
REQ-002 SHALL have parameter DEPTH, default 4, queue entries; power of two and at least 2.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port inst_rdaddress  output  WIDTH  word address to instruction memory; read data returns on inst_q exactly one cycle after inst_rden.
REQ-006 SHALL have port inst_rden  output  1  instruction memory read enable.
REQ-007 SHALL have port inst_q  input  WIDTH  instruction memory read data.
REQ-008 SHALL have port redirect  input  1  flush the queue and restart fetch at redirect_pc (taken branch).
REQ-009 SHALL have port redirect_pc  input  WIDTH  restart word address.
REQ-010 SHALL have port out_valid  output  1  head entry valid.
REQ-011 SHALL have port out_inst  output  WIDTH  head instruction.
REQ-012 SHALL have port out_pc  output  WIDTH  word address of the head instruction.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the head this cycle.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-015 SHALL keep fetch_pc, a word address that increments by 1 per issued read; inst_rdaddress = fetch_pc.
REQ-016 SHALL assert inst_rden only when reset=0, redirect=0, and count + inflight < DEPTH, where inflight = inst_rden of the previous cycle. Pops in the same cycle give no credit.
REQ-017 SHALL record the issued address in req_pc. On the next edge, if the read was not discarded, SHALL write {inst_q, req_pc} to the tail.
REQ-018 SHALL never overflow: a push at count = DEPTH is impossible by REQ-016, and a bench assertion SHALL check this.
REQ-019 SHALL drive out_valid = (count != 0); out_inst and out_pc SHALL come combinationally from the head entry.
REQ-020 SHALL drive out_inst = 0 (NOP) and out_pc = 0 whenever out_valid = 0.
REQ-021 SHALL pop the head on an edge where out_valid and out_ready are both 1. Push and pop in the same cycle SHALL leave count unchanged.
REQ-022 SHALL use head and tail pointers that wrap modulo DEPTH.
REQ-023 SHALL give first-instruction latency of 2 cycles: an issue in cycle N makes the entry visible in cycle N+2.
REQ-024 SHALL sustain one instruction per cycle when out_ready is held 1.
REQ-025 On a cycle with redirect = 1, SHALL:
  - clear count and both pointers;
  - set fetch_pc to redirect_pc;
  - drop any in-flight response (no push on that edge or the next);
  - ignore out_ready, so no pop occurs;
  - issue the read of redirect_pc in the following cycle.
REQ-026 SHALL treat back-to-back redirects as follows: the last one wins, and nothing is issued while redirect = 1.
REQ-027 SHALL let fetch_pc wrap from 2^WIDTH-1 to 0 without error.

Reset
REQ-028 With reset = 1 on an edge, SHALL set fetch_pc = 0, count = 0, pointers = 0, inflight = 0, and discard = 0.
REQ-029 During reset, SHALL drive inst_rden = 0, out_valid = 0, out_inst = 0, and out_pc = 0.
REQ-030 SHALL give reset priority over redirect, push and pop.
REQ-031 SHALL discard any in-flight read when reset is asserted mid-operation.
REQ-032 After reset deasserts, SHALL issue address 0 in the first cycle.

Verification
REQ-033 Stream test: memory[i] = 0x100 + i, out_ready held 1 after reset, DEPTH = 4 -> from cycle 2, out_valid = 1 every cycle with out_pc = 0, 1, 2, ... and out_inst = 0x100, 0x101, ...
REQ-034 Fill test: out_ready = 0 for 10 cycles -> count saturates at 4, inst_rden = 0 once count + inflight = 4, and fetch_pc = 4.
REQ-035 Drain test: raise out_ready from the fill state -> entries 0..3 pop in order, then refetch continues at pc 4 with no gap beyond 2 cycles.
REQ-036 Redirect test: redirect = 1 with redirect_pc = 0x20 while 3 entries are queued and a read is in flight -> next cycle count = 0 and out_valid = 0; the read of 0x20 issues, and 2 cycles later out_pc = 0x20 with no stale entry delivered.
REQ-037 Simultaneous push and pop at count = 3 -> count stays 3 and order is preserved.
REQ-038 Reset mid-stream: reset pulsed for 1 cycle at count = 2 -> outputs match REQ-029 in the reset cycle, and stream restarts at pc 0 with out_inst = memory[0].
